enhance_fsm: RTL and testbench

- Vending-machine controller for a drink priced at 2.5 units.
- Two coin inputs: `pay` = 1.0 unit, `pay_half` = 0.5 unit.
- Accumulates credit in half-unit steps. Dispenses (`coke`) once credit reaches the price. Returns 0.5 change (`ret`) when the final coin overshoots.
- Sits behind the coin-acceptor front end, which delivers one-cycle coin strobes synchronous to `sys_clk`.

---
 rtl/enhance_fsm.sv | 84 ++++++++
 tb/tb_enhance_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/enhance_fsm.sv
// enhance_fsm: vending-machine controller, price in half-unit coins.
// Optional `credit` output when ENHANCE_FSM_CREDIT_OUT_EN is defined.
module enhance_fsm #(
    parameter int unsigned PRICE_HALVES = 5
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pay,
    input  logic       pay_half,
`ifdef ENHANCE_FSM_CREDIT_OUT_EN
    output logic [3:0] credit,
`endif
    output logic       ret,
    output logic       coke
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] HALF     = 4'd1;
    localparam logic [3:0] ONE      = 4'd2;
    localparam logic [3:0] ONE_HALF = 4'd3;
    localparam logic [3:0] TWO      = 4'd4;

    localparam logic [4:0] PRICE = 5'(PRICE_HALVES);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       coke_nxt;
    logic       ret_nxt;
    logic [1:0] coin_v;
    logic [4:0] sum;

    // Coin value in half-units; a full coin masks a simultaneous half coin
    always_comb begin
        coin_v = 2'd0;
        priority case (1'b1)
            pay:      coin_v = 2'd2;
            pay_half: coin_v = 2'd1;
            default:  coin_v = 2'd0;
        endcase
    end

    assign sum = {1'b0, state} + {3'b000, coin_v};

    // Next credit and dispense/change decisions
    always_comb begin
        state_nxt = state;
        coke_nxt  = 1'b0;
        ret_nxt   = 1'b0;
        if ({1'b0, state} >= PRICE) begin
            state_nxt = IDLE;
        end else if (sum < PRICE) begin
            state_nxt = sum[3:0];
        end else if (sum == PRICE) begin
            state_nxt = IDLE;
            coke_nxt  = 1'b1;
        end else begin
            state_nxt = IDLE;
            coke_nxt  = 1'b1;
            ret_nxt   = 1'b1;
        end
    end

    // Credit register and registered output pulses
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            coke  <= 1'b0;
            ret   <= 1'b0;
        end else begin
            state <= state_nxt;
            coke  <= coke_nxt;
            ret   <= ret_nxt;
        end
    end

`ifdef ENHANCE_FSM_CREDIT_OUT_EN
    assign credit = state;
`endif

    // Named default-price states kept for readability in waveforms
    logic unused_names;
    assign unused_names = ^{HALF, ONE, ONE_HALF, TWO};

endmodule

// File: tb/tb_enhance_fsm.sv
// tb_enhance_fsm: scoreboard bench for enhance_fsm.
// Driver pushes expected pulses; negedge monitor pops and compares.
module tb_enhance_fsm;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic pay;
    logic pay_half;
    logic ret;
    logic coke;
`ifdef ENHANCE_FSM_CREDIT_OUT_EN
    logic [3:0] credit;
    int cred_exp = 0;
`endif

    typedef struct {
        int cyc;
        bit r;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int model_c = 0;
    int n_chk = 0;
    int n_fail = 0;

    localparam int PRICE = 5;

    enhance_fsm dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .pay      (pay),
        .pay_half (pay_half),
`ifdef ENHANCE_FSM_CREDIT_OUT_EN
        .credit   (credit),
`endif
        .ret      (ret),
        .coke     (coke)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Drive one coin after the edge; model the purchase it may complete
    task automatic coin(input bit p, input bit h);
        int v;
        int s;
        @(posedge sys_clk);
        #1;
        pay = p;
        pay_half = h;
        v = p ? 2 : (h ? 1 : 0);
        s = model_c + v;
        if (s < PRICE) begin
            model_c = s;
        end else begin
            exp_t e;
            e.cyc = cyc + 1;
            e.r = (s == PRICE + 1);
            sb.push_back(e);
            model_c = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            pay = 1'b0;
            pay_half = 1'b0;
        end
    endtask

`ifdef ENHANCE_FSM_CREDIT_OUT_EN
    always @(posedge sys_clk) cred_exp <= model_c;
`endif

    // Monitor: every pulse must match the head of the scoreboard
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (coke || ret) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: coke=%0b ret=%0b expected none (cyc %0d)",
                             coke, ret, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("coke_with_pulse", int'(coke), 1);
                    check("ret", int'(ret), int'(e.r));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missed_pulse: got none expected at cyc %0d (cyc %0d)",
                         sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
`ifdef ENHANCE_FSM_CREDIT_OUT_EN
            check("credit", int'(credit), cred_exp);
`endif
        end
    end

    initial begin
        bit b;
        sys_rst = 1'b1;
        pay = 1'b0;
        pay_half = 1'b0;
        #1;
        check("reset_coke", int'(coke), 0);
        check("reset_ret", int'(ret), 0);
        #11;
        sys_rst = 1'b0;

        // Reset mid-accumulation discards credit
        coin(1, 0);
        idle(1);
        sys_rst = 1'b1;
        model_c = 0;
        #1;
        check("mid_reset_coke", int'(coke), 0);
        check("mid_reset_ret", int'(ret), 0);
        repeat (3) @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        repeat (5) coin(0, 1);
        idle(2);

        // Exact price with halves
        repeat (5) coin(0, 1);
        idle(2);

        // Overpay
        repeat (3) coin(1, 0);
        idle(2);

        // Mixed exact orders
        coin(1, 0); coin(1, 0); coin(0, 1);
        idle(1);
        coin(1, 0); coin(0, 1); coin(1, 0);
        idle(2);

        // Simultaneous coins, with idle gaps
        repeat (3) coin(1, 1);
        idle(1);
        coin(1, 1); idle(1);
        coin(1, 1); idle(2);
        coin(1, 1);
        idle(2);

        // Async reset clears a live pulse immediately
        repeat (3) coin(1, 0);
        idle(1);
        check("pre_reset_coke", int'(coke), 1);
        check("pre_reset_ret", int'(ret), 1);
        sys_rst = 1'b1;
        #1;
        check("async_clr_coke", int'(coke), 0);
        check("async_clr_ret", int'(ret), 0);
        check("sb_pending", sb.size(), 1);
        sb.delete();
        model_c = 0;
        repeat (2) @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;

        // Back-to-back purchases with no dead cycle
        repeat (5) coin(1, 0);
        coin(0, 1);
        idle(2);

        // Alternating random stream
        repeat (100) begin
            b = 1'($urandom_range(0, 1));
            coin(b, !b);
        end
        idle(3);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
